// File: rtl/ingress_port_fifo_pkg.sv
// ingress_port_fifo_pkg: write-FSM state encodings and default sizing shared by all ingress FIFO instances
package ingress_port_fifo_pkg;
  localparam int DATA_WIDTH = 64;
  localparam int FIFO_DEPTH = 64;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_RECV = 2'd1, W_DROP = 2'd2} w_state_e;
endpackage

// File: rtl/ingress_buffer_mem.sv
// ingress_buffer_mem: depth x width word store, sync write (i_we/i_waddr/i_wdata on clk), async read (i_raddr -> o_rdata)
module ingress_buffer_mem #(
  parameter int width = 66,
  parameter int depth = 64,
  localparam int aw = $clog2(depth)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [aw-1:0]    i_waddr,
  input  logic [width-1:0] i_wdata,
  input  logic [aw-1:0]    i_raddr,
  output logic [width-1:0] o_rdata
);
  logic [width-1:0] r_mem [depth];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/ingress_port_fifo.sv
// ingress_port_fifo: packet FIFO committing whole packets; wr_* packet input, next_data pops, ready/vld/sop/eop/data_out head view, drop pulses per discarded packet
module ingress_port_fifo
  import ingress_port_fifo_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int fifo_depth = FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_sop,
  input  logic                  wr_eop,
  input  logic                  wr_vld,
  input  logic [data_width-1:0] wr_data,
  input  logic                  next_data,
  output logic                  ready,
  output logic                  sop,
  output logic                  eop,
  output logic                  vld,
  output logic [data_width-1:0] data_out,
  output logic                  drop
);
  localparam int aw = $clog2(fifo_depth);
  typedef logic [aw:0] ptr_t;
  w_state_e r_state, w_state_nx;
  ptr_t r_wr_ptr, r_commit_ptr, r_pkt_start, r_rd_ptr, r_pkt_cnt;
  ptr_t w_wr_ptr_nx, w_commit_ptr_nx, w_pkt_start_nx, w_used, w_base, w_wr_at;
  logic w_full, w_start, w_cont, w_we, w_rej, w_commit, w_pop, w_pop_eop, w_drop, r_drop;
  logic [data_width+1:0] w_rdata;
  assign w_used = r_wr_ptr - r_rd_ptr;
  assign w_full = w_used == ptr_t'(fifo_depth);
  assign w_start = wr_vld & wr_sop;
  assign w_cont = wr_vld & ~wr_sop & (r_state == W_RECV);
  assign w_base = (r_state == W_RECV) ? r_pkt_start : r_wr_ptr;
  assign w_wr_at = w_start ? w_base : r_wr_ptr;
  assign w_we = (w_start | w_cont) & ~w_full;
  assign w_rej = (w_start | w_cont) & w_full;
  assign w_commit = w_we & wr_eop;
  assign w_drop = (w_start & (r_state == W_RECV)) | w_rej;
  assign w_pop = next_data & vld;
  assign w_pop_eop = w_pop & w_rdata[data_width];
  // a rejected word rewinds to the packet start; the next state waits for eop unless this word already ended the packet
  always_comb begin
    w_state_nx = w_we ? (wr_eop ? W_IDLE : W_RECV) :
                 w_rej ? (wr_eop ? W_IDLE : W_DROP) :
                 (wr_vld & wr_eop & (r_state == W_DROP)) ? W_IDLE : r_state;
    w_wr_ptr_nx = w_we ? w_wr_at + 1'b1 : w_rej ? w_base : r_wr_ptr;
    w_pkt_start_nx = (w_start | w_rej) ? w_base : r_pkt_start;
    w_commit_ptr_nx = w_commit ? w_wr_at + 1'b1 : r_commit_ptr;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= W_IDLE;
      r_wr_ptr <= '0;
      r_commit_ptr <= '0;
      r_pkt_start <= '0;
      r_rd_ptr <= '0;
      r_pkt_cnt <= '0;
      r_drop <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_wr_ptr <= w_wr_ptr_nx;
      r_commit_ptr <= w_commit_ptr_nx;
      r_pkt_start <= w_pkt_start_nx;
      r_rd_ptr <= r_rd_ptr + ptr_t'(w_pop);
      r_pkt_cnt <= r_pkt_cnt + ptr_t'(w_commit) - ptr_t'(w_pop_eop);
      r_drop <= w_drop;
    end
  ingress_buffer_mem #(.width(data_width + 2), .depth(fifo_depth)) u_mem (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(w_wr_at[aw-1:0]),
    .i_wdata({wr_sop, wr_eop, wr_data}),
    .i_raddr(r_rd_ptr[aw-1:0]),
    .o_rdata(w_rdata)
  );
  // head view is blanked when nothing committed so stale memory never leaks out
  assign vld = r_rd_ptr != r_commit_ptr;
  assign ready = r_pkt_cnt != '0;
  assign {sop, eop, data_out} = vld ? w_rdata : '0;
  assign drop = r_drop;
endmodule
